// File: rtl/as_jtag_imem_tap.sv
// JTAG TAP controller clocked entirely from clk_i that exposes an instruction
// memory scan chain (IMSCAN). TCK, TMS, TDI and TRST are oversampled through
// 2-flop synchronizers, and all TAP actions are keyed off detected TCK edges.
module as_jtag_imem_tap #(
    parameter int          IR_W        = 8,
    parameter int          IMEM_ADDR_W = 12,
    parameter int          INSTR_W     = 32,
    parameter logic [31:0] IDCODE_VAL  = 32'h1000_0001
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   tck_i,
    input  logic                   trst_i,
    input  logic                   tms_i,
    input  logic                   tdi_i,
    output logic                   tdo_o,
    input  logic [INSTR_W-1:0]     imrdata_i,
    output logic [IMEM_ADDR_W-1:0] imaddr_o,
    output logic [INSTR_W-1:0]     instr_o,
    output logic                   imwe_o
);

    localparam int SCAN_W = IMEM_ADDR_W + INSTR_W + 1;

    localparam logic [IR_W-1:0] IR_IDCODE  = IR_W'(8'h01);
    localparam logic [IR_W-1:0] IR_IMSCAN  = IR_W'(8'h80);
    localparam logic [IR_W-1:0] IR_CAPTURE = IR_W'(8'b0000_0001);

    localparam logic [3:0] ST_TLR      = 4'h0;
    localparam logic [3:0] ST_RTI      = 4'h1;
    localparam logic [3:0] ST_SEL_DR   = 4'h2;
    localparam logic [3:0] ST_CAP_DR   = 4'h3;
    localparam logic [3:0] ST_SHIFT_DR = 4'h4;
    localparam logic [3:0] ST_EXIT1_DR = 4'h5;
    localparam logic [3:0] ST_PAUSE_DR = 4'h6;
    localparam logic [3:0] ST_EXIT2_DR = 4'h7;
    localparam logic [3:0] ST_UPD_DR   = 4'h8;
    localparam logic [3:0] ST_SEL_IR   = 4'h9;
    localparam logic [3:0] ST_CAP_IR   = 4'hA;
    localparam logic [3:0] ST_SHIFT_IR = 4'hB;
    localparam logic [3:0] ST_EXIT1_IR = 4'hC;
    localparam logic [3:0] ST_PAUSE_IR = 4'hD;
    localparam logic [3:0] ST_EXIT2_IR = 4'hE;
    localparam logic [3:0] ST_UPD_IR   = 4'hF;

    // synchronizer and edge-detect flops
    logic tck_meta_r, tck_sync_r, tck_dly_r;
    logic tms_meta_r, tms_sync_r;
    logic tdi_meta_r, tdi_sync_r;
    logic trst_meta_r, trst_sync_r;

    logic tck_rise_s, tck_fall_s;

    logic [3:0]             state_r;
    logic [3:0]             next_state_s;
    logic [IR_W-1:0]        ir_r;
    logic [IR_W-1:0]        ir_sr_r;
    logic [31:0]            idcode_sr_r;
    logic                   bypass_sr_r;
    logic [SCAN_W-1:0]      scan_sr_r;
    logic                   sel_idcode_s;
    logic                   sel_imscan_s;
    logic                   enter_upd_dr_s;
    logic                   enter_upd_ir_s;
    logic                   in_shift_s;
    logic                   tdo_src_s;
    logic                   tdo_r;
    logic [IMEM_ADDR_W-1:0] imaddr_r;
    logic [INSTR_W-1:0]     instr_r;
    logic                   imwe_r;

    // Bring the asynchronous JTAG pins into the clk_i domain and delay TCK once more for edge detection
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            tck_meta_r  <= 1'b0;
            tck_sync_r  <= 1'b0;
            tck_dly_r   <= 1'b0;
            tms_meta_r  <= 1'b0;
            tms_sync_r  <= 1'b0;
            tdi_meta_r  <= 1'b0;
            tdi_sync_r  <= 1'b0;
            trst_meta_r <= 1'b0;
            trst_sync_r <= 1'b0;
        end else begin
            tck_meta_r  <= tck_i;
            tck_sync_r  <= tck_meta_r;
            tck_dly_r   <= tck_sync_r;
            tms_meta_r  <= tms_i;
            tms_sync_r  <= tms_meta_r;
            tdi_meta_r  <= tdi_i;
            tdi_sync_r  <= tdi_meta_r;
            trst_meta_r <= trst_i;
            trst_sync_r <= trst_meta_r;
        end
    end

    assign tck_rise_s = tck_sync_r & ~tck_dly_r;
    assign tck_fall_s = ~tck_sync_r & tck_dly_r;

    // Standard IEEE 1149.1 TMS transition table
    always_comb begin
        next_state_s = ST_TLR;
        case (state_r)
            ST_TLR:      next_state_s = tms_sync_r ? ST_TLR      : ST_RTI;
            ST_RTI:      next_state_s = tms_sync_r ? ST_SEL_DR   : ST_RTI;
            ST_SEL_DR:   next_state_s = tms_sync_r ? ST_SEL_IR   : ST_CAP_DR;
            ST_CAP_DR:   next_state_s = tms_sync_r ? ST_EXIT1_DR : ST_SHIFT_DR;
            ST_SHIFT_DR: next_state_s = tms_sync_r ? ST_EXIT1_DR : ST_SHIFT_DR;
            ST_EXIT1_DR: next_state_s = tms_sync_r ? ST_UPD_DR   : ST_PAUSE_DR;
            ST_PAUSE_DR: next_state_s = tms_sync_r ? ST_EXIT2_DR : ST_PAUSE_DR;
            ST_EXIT2_DR: next_state_s = tms_sync_r ? ST_UPD_DR   : ST_SHIFT_DR;
            ST_UPD_DR:   next_state_s = tms_sync_r ? ST_SEL_DR   : ST_RTI;
            ST_SEL_IR:   next_state_s = tms_sync_r ? ST_TLR      : ST_CAP_IR;
            ST_CAP_IR:   next_state_s = tms_sync_r ? ST_EXIT1_IR : ST_SHIFT_IR;
            ST_SHIFT_IR: next_state_s = tms_sync_r ? ST_EXIT1_IR : ST_SHIFT_IR;
            ST_EXIT1_IR: next_state_s = tms_sync_r ? ST_UPD_IR   : ST_PAUSE_IR;
            ST_PAUSE_IR: next_state_s = tms_sync_r ? ST_EXIT2_IR : ST_PAUSE_IR;
            ST_EXIT2_IR: next_state_s = tms_sync_r ? ST_UPD_IR   : ST_SHIFT_IR;
            ST_UPD_IR:   next_state_s = tms_sync_r ? ST_SEL_DR   : ST_RTI;
            default:     next_state_s = ST_TLR;
        endcase
    end

    // Instruction decode; every code other than IDCODE and IMSCAN selects BYPASS
    always_comb begin
        sel_idcode_s = 1'b0;
        sel_imscan_s = 1'b0;
        if (ir_r == IR_IDCODE) begin
            sel_idcode_s = 1'b1;
        end else if (ir_r == IR_IMSCAN) begin
            sel_imscan_s = 1'b1;
        end else begin
            sel_idcode_s = 1'b0;
        end
    end

    // Update actions fire only on the TCK rise that first enters an Update state
    assign enter_upd_dr_s = tck_rise_s && (next_state_s == ST_UPD_DR) && (state_r != ST_UPD_DR);
    assign enter_upd_ir_s = tck_rise_s && (next_state_s == ST_UPD_IR) && (state_r != ST_UPD_IR);
    assign in_shift_s     = (state_r == ST_SHIFT_DR) || (state_r == ST_SHIFT_IR);

    // TAP state register, advanced only on a detected TCK rise
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_r <= ST_TLR;
        end else if (trst_sync_r) begin
            state_r <= ST_TLR;
        end else if (tck_rise_s) begin
            state_r <= next_state_s;
        end else begin
            state_r <= state_r;
        end
    end

    // Instruction register and its shift stage
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            ir_r    <= IR_IDCODE;
            ir_sr_r <= '0;
        end else if (trst_sync_r || (state_r == ST_TLR)) begin
            ir_r    <= IR_IDCODE;
            ir_sr_r <= ir_sr_r;
        end else begin
            if (enter_upd_ir_s) begin
                ir_r <= ir_sr_r;
            end
            if (tck_rise_s && (state_r == ST_CAP_IR)) begin
                ir_sr_r <= IR_CAPTURE;
            end else if (tck_rise_s && (state_r == ST_SHIFT_IR)) begin
                ir_sr_r <= {ir_sr_r[IR_W-2:0], tdi_sync_r};
            end
        end
    end

    // Data registers: capture on the rise leaving Capture-DR, shift on every rise in Shift-DR
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            idcode_sr_r <= '0;
            bypass_sr_r <= 1'b0;
            scan_sr_r   <= '0;
        end else if (tck_rise_s && (state_r == ST_CAP_DR) && !trst_sync_r) begin
            if (sel_idcode_s) begin
                idcode_sr_r <= IDCODE_VAL;
            end else if (sel_imscan_s) begin
                scan_sr_r <= {imaddr_r, imrdata_i, 1'b0};
            end else begin
                bypass_sr_r <= 1'b0;
            end
        end else if (tck_rise_s && (state_r == ST_SHIFT_DR) && !trst_sync_r) begin
            if (sel_idcode_s) begin
                idcode_sr_r <= {idcode_sr_r[30:0], tdi_sync_r};
            end else if (sel_imscan_s) begin
                scan_sr_r <= {scan_sr_r[SCAN_W-2:0], tdi_sync_r};
            end else begin
                bypass_sr_r <= tdi_sync_r;
            end
        end
    end

    // I-Mem address/data latch and single-cycle write strobe on entry into Update-DR
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            imaddr_r <= '0;
            instr_r  <= '0;
            imwe_r   <= 1'b0;
        end else if (trst_sync_r) begin
            imwe_r   <= 1'b0;
        end else if (enter_upd_dr_s && sel_imscan_s) begin
            imaddr_r <= scan_sr_r[SCAN_W-1 -: IMEM_ADDR_W];
            instr_r  <= scan_sr_r[INSTR_W:1];
            imwe_r   <= scan_sr_r[0];
        end else begin
            imwe_r   <= 1'b0;
        end
    end

    // Select the MSB of whichever shift register is live in the current Shift state
    always_comb begin
        tdo_src_s = 1'b0;
        if (state_r == ST_SHIFT_IR) begin
            tdo_src_s = ir_sr_r[IR_W-1];
        end else if (sel_idcode_s) begin
            tdo_src_s = idcode_sr_r[31];
        end else if (sel_imscan_s) begin
            tdo_src_s = scan_sr_r[SCAN_W-1];
        end else begin
            tdo_src_s = bypass_sr_r;
        end
    end

    // TDO changes on the TCK fall while shifting and is held low outside Shift states
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            tdo_r <= 1'b0;
        end else if (trst_sync_r || !in_shift_s) begin
            tdo_r <= 1'b0;
        end else if (tck_fall_s) begin
            tdo_r <= tdo_src_s;
        end else begin
            tdo_r <= tdo_r;
        end
    end

    assign tdo_o    = tdo_r;
    assign imaddr_o = imaddr_r;
    assign instr_o  = instr_r;
    assign imwe_o   = imwe_r;

endmodule
